// File: rtl/uart_pkg.sv
// Shared UART types, legal parameter limits and parity helper.
// Common to uart_tx and the future uart_rx.
package uart_pkg;

    localparam int unsigned CLK_DIV_MIN   = 2;
    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;
    localparam int unsigned PARITY_MAX    = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

    // Unused upper bits must be zero so they do not disturb the reduction.
    function automatic logic parity_bit(input parity_e mode, input logic [DATA_BITS_MAX-1:0] word);
        return (mode == PAR_EVEN) ? (^word) : (~^word);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between a byte producer and the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// Holding clr_i parks the counter at zero so the next bit starts aligned.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic bit_tick_c
);
    localparam int unsigned          CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
        $fatal(1, "uart_baud_gen: CLK_DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits. Word is captured on valid/ready acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  tx_if,
    output logic      tx_serial,
    output logic      tx_busy,
    output logic      tx_done
);
    localparam int unsigned       BCNT_W    = $clog2(DATA_BITS + 1);
    localparam parity_e           PAR_MODE  = parity_e'(2'(PARITY));
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY > PARITY_MAX) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 bit_tick;
    logic                 baud_clr;

    assign baud_clr = (state_q == ST_IDLE);

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (baud_clr),
        .bit_tick_c (bit_tick)
    );

    // Outputs are registered from the next state so each level starts on the transition edge.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_if.tx_valid && ready_q) begin
                    state_d  = ST_START;
                    shreg_d  = tx_if.tx_data;
                    par_d    = parity_bit(PAR_MODE, DATA_BITS_MAX'(tx_if.tx_data));
                    bitcnt_d = '0;
                    serial_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d  = ST_DATA;
                    serial_d = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
                        if (PAR_MODE != PAR_NONE) begin
                            state_d  = ST_PAR;
                            serial_d = par_q;
                        end else begin
                            state_d  = ST_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BCNT_W'(1);
                        serial_d = shreg_q[1];
                    end
                end
            end
            ST_PAR: begin
                if (bit_tick) begin
                    state_d  = ST_STOP;
                    bitcnt_d = '0;
                    serial_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bitcnt_q == LAST_STOP) begin
                        state_d  = ST_IDLE;
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign tx_if.tx_ready = ready_q;
    assign tx_serial      = serial_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations (8N1, 8E1, 8O1, 5N2) sharing one clock and reset.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [3:0] valid_v;
    logic [8:0] data_v [4];
    logic [3:0] serial_w, busy_w, done_w, ready_w;
    int         n_checks;
    int         n_pass;

    uart_tx_if #(.DATA_BITS(8)) if_a ();
    uart_tx_if #(.DATA_BITS(8)) if_b ();
    uart_tx_if #(.DATA_BITS(8)) if_c ();
    uart_tx_if #(.DATA_BITS(5)) if_d ();

    assign if_a.tx_valid = valid_v[0];
    assign if_b.tx_valid = valid_v[1];
    assign if_c.tx_valid = valid_v[2];
    assign if_d.tx_valid = valid_v[3];
    assign if_a.tx_data  = data_v[0][7:0];
    assign if_b.tx_data  = data_v[1][7:0];
    assign if_c.tx_data  = data_v[2][7:0];
    assign if_d.tx_data  = data_v[3][4:0];
    assign ready_w       = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .tx_if(if_a),
        .tx_serial(serial_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .tx_if(if_b),
        .tx_serial(serial_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .reset(reset), .tx_if(if_c),
        .tx_serial(serial_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.CLK_DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_d (
        .clk(clk), .reset(reset), .tx_if(if_d),
        .tx_serial(serial_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid and step through the accepting edge; returns in the first frame cycle.
    task automatic accept(input int d, input logic [8:0] word, output bit ok);
        ok        = 1'b0;
        data_v[d] = word;
        valid_v[d] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (ready_w[d] === 1'b1) ok = 1'b1;
            tick();
        end
    endtask

    // Samples the line for a whole frame: first level of each bit, hold/quiet/busy flags.
    task automatic run_frame(input int d, input int nbits, input int cdiv,
                             output logic [15:0] bits, output bit stable, output bit quiet, output bit held);
        bits = '0; stable = 1'b1; quiet = 1'b1; held = 1'b1;
        for (int c = 0; c < nbits * cdiv; c++) begin
            if (c % cdiv == 0) bits[c / cdiv] = serial_w[d];
            else if (serial_w[d] !== bits[c / cdiv]) stable = 1'b0;
            if (done_w[d] !== 1'b0) quiet = 1'b0;
            if (busy_w[d] !== 1'b1 || ready_w[d] !== 1'b0) held = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (serial_w[d] !== 1'b1) $display("FAIL rst_serial[%0d]: got %b want 1", d, serial_w[d]); else n_pass++;
            n_checks++; if (ready_w[d] !== 1'b1) $display("FAIL rst_ready[%0d]: got %b want 1", d, ready_w[d]); else n_pass++;
            n_checks++; if (busy_w[d] !== 1'b0) $display("FAIL rst_busy[%0d]: got %b want 0", d, busy_w[d]); else n_pass++;
            n_checks++; if (done_w[d] !== 1'b0) $display("FAIL rst_done[%0d]: got %b want 0", d, done_w[d]); else n_pass++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_8n1();
        logic [15:0] bits; bit ok, stable, quiet, held;
        accept(0, 9'h0A5, ok);
        valid_v[0] = 1'b0;
        n_checks++; if (!ok) $display("FAIL 8n1_accept: got no accept want accept"); else n_pass++;
        run_frame(0, 10, 4, bits, stable, quiet, held);
        n_checks++; if (bits[9:0] !== 10'b1101001010) $display("FAIL 8n1_bits: got %b want %b", bits[9:0], 10'b1101001010); else n_pass++;
        n_checks++; if (!stable) $display("FAIL 8n1_hold: got unstable bit want 4-cycle levels"); else n_pass++;
        n_checks++; if (!quiet) $display("FAIL 8n1_early_done: got done inside frame want none"); else n_pass++;
        n_checks++; if (!held) $display("FAIL 8n1_busy: got busy/ready glitch want busy=1 ready=0"); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b1) $display("FAIL 8n1_done41: got %b want 1", done_w[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL 8n1_busy41: got %b want 0", busy_w[0]); else n_pass++;
        n_checks++; if (ready_w[0] !== 1'b1) $display("FAIL 8n1_ready41: got %b want 1", ready_w[0]); else n_pass++;
        n_checks++; if (serial_w[0] !== 1'b1) $display("FAIL 8n1_idle41: got %b want 1", serial_w[0]); else n_pass++;
        tick();
        n_checks++; if (done_w[0] !== 1'b0) $display("FAIL 8n1_done_pulse: got %b want 0", done_w[0]); else n_pass++;
    endtask

    task automatic test_parity();
        logic [15:0] bits; bit ok, stable, quiet, held;
        accept(1, 9'h007, ok);
        valid_v[1] = 1'b0;
        n_checks++; if (!ok) $display("FAIL even_accept: got no accept want accept"); else n_pass++;
        run_frame(1, 11, 4, bits, stable, quiet, held);
        n_checks++; if (bits[10:0] !== 11'b11000001110) $display("FAIL even_bits: got %b want %b", bits[10:0], 11'b11000001110); else n_pass++;
        n_checks++; if (!(stable && quiet)) $display("FAIL even_frame: got stable=%b quiet=%b want 1 1", stable, quiet); else n_pass++;
        n_checks++; if (done_w[1] !== 1'b1) $display("FAIL even_done45: got %b want 1", done_w[1]); else n_pass++;
        accept(2, 9'h007, ok);
        valid_v[2] = 1'b0;
        n_checks++; if (!ok) $display("FAIL odd_accept: got no accept want accept"); else n_pass++;
        run_frame(2, 11, 4, bits, stable, quiet, held);
        n_checks++; if (bits[10:0] !== 11'b10000001110) $display("FAIL odd_bits: got %b want %b", bits[10:0], 11'b10000001110); else n_pass++;
        n_checks++; if (!(stable && quiet)) $display("FAIL odd_frame: got stable=%b quiet=%b want 1 1", stable, quiet); else n_pass++;
        n_checks++; if (done_w[2] !== 1'b1) $display("FAIL odd_done45: got %b want 1", done_w[2]); else n_pass++;
    endtask

    task automatic test_width_stop();
        logic [15:0] bits; bit ok, stable, quiet, held;
        accept(3, 9'h01F, ok);
        valid_v[3] = 1'b0;
        n_checks++; if (!ok) $display("FAIL 5n2_accept: got no accept want accept"); else n_pass++;
        run_frame(3, 8, 3, bits, stable, quiet, held);
        n_checks++; if (bits[7:0] !== 8'b11111110) $display("FAIL 5n2_bits: got %b want %b", bits[7:0], 8'b11111110); else n_pass++;
        n_checks++; if (!(stable && quiet && held)) $display("FAIL 5n2_frame: got stable=%b quiet=%b held=%b want 1 1 1", stable, quiet, held); else n_pass++;
        n_checks++; if (done_w[3] !== 1'b1) $display("FAIL 5n2_done25: got %b want 1", done_w[3]); else n_pass++;
        tick();
        n_checks++; if (done_w[3] !== 1'b0) $display("FAIL 5n2_done_pulse: got %b want 0", done_w[3]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; bit ok, stable, quiet, held;
        accept(0, 9'h055, ok);
        data_v[0] = 9'h0AA;
        n_checks++; if (!ok) $display("FAIL b2b_accept: got no accept want accept"); else n_pass++;
        run_frame(0, 10, 4, bits, stable, quiet, held);
        n_checks++; if (bits[9:0] !== 10'b1010101010) $display("FAIL b2b_bits1: got %b want %b", bits[9:0], 10'b1010101010); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b1) $display("FAIL b2b_done1: got %b want 1", done_w[0]); else n_pass++;
        n_checks++; if (serial_w[0] !== 1'b1) $display("FAIL b2b_gap: got %b want 1", serial_w[0]); else n_pass++;
        tick();
        valid_v[0] = 1'b0;
        n_checks++; if (serial_w[0] !== 1'b0) $display("FAIL b2b_start2: got %b want 0", serial_w[0]); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", done_w[0]); else n_pass++;
        run_frame(0, 10, 4, bits, stable, quiet, held);
        n_checks++; if (bits[9:0] !== 10'b1101010100) $display("FAIL b2b_bits2: got %b want %b", bits[9:0], 10'b1101010100); else n_pass++;
        n_checks++; if (!(stable && quiet)) $display("FAIL b2b_frame2: got stable=%b quiet=%b want 1 1", stable, quiet); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b1) $display("FAIL b2b_done2: got %b want 1", done_w[0]); else n_pass++;
        tick();
    endtask

    task automatic test_ignored();
        logic [15:0] bits; bit ok, stable, quiet, held, idle;
        accept(0, 9'h096, ok);
        valid_v[0] = 1'b0;
        n_checks++; if (!ok) $display("FAIL ign_accept: got no accept want accept"); else n_pass++;
        fork
            run_frame(0, 10, 4, bits, stable, quiet, held);
            begin
                for (int i = 0; i < 36; i++) begin
                    data_v[0]  = 9'($urandom);
                    valid_v[0] = i[0];
                    tick();
                end
                valid_v[0] = 1'b0;
            end
        join
        n_checks++; if (bits[9:0] !== 10'b1100101100) $display("FAIL ign_bits: got %b want %b", bits[9:0], 10'b1100101100); else n_pass++;
        n_checks++; if (!held) $display("FAIL ign_ready: got ready/busy change mid-frame want ready=0 busy=1"); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b1) $display("FAIL ign_done: got %b want 1", done_w[0]); else n_pass++;
        idle = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (serial_w[0] !== 1'b1 || busy_w[0] !== 1'b0) idle = 1'b0;
            tick();
        end
        n_checks++; if (!idle) $display("FAIL ign_extra_frame: got line activity want idle"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits; bit ok, stable, quiet, held, idle;
        accept(0, 9'h0A5, ok);
        valid_v[0] = 1'b0;
        n_checks++; if (!ok) $display("FAIL rmid_accept: got no accept want accept"); else n_pass++;
        repeat (17) tick();
        n_checks++; if (serial_w[0] !== 1'b0) $display("FAIL rmid_bit3: got %b want 0", serial_w[0]); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (serial_w[0] !== 1'b1) $display("FAIL rmid_async_serial: got %b want 1", serial_w[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL rmid_async_busy: got %b want 0", busy_w[0]); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        idle = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (done_w[0] !== 1'b0 || serial_w[0] !== 1'b1) idle = 1'b0;
            tick();
        end
        n_checks++; if (!idle) $display("FAIL rmid_no_done: got done or activity after reset want none"); else n_pass++;
        accept(0, 9'h03C, ok);
        valid_v[0] = 1'b0;
        n_checks++; if (!ok) $display("FAIL rmid_reaccept: got no accept want accept"); else n_pass++;
        run_frame(0, 10, 4, bits, stable, quiet, held);
        n_checks++; if (bits[9:0] !== 10'b1001111000) $display("FAIL rmid_bits: got %b want %b", bits[9:0], 10'b1001111000); else n_pass++;
        n_checks++; if (!(stable && quiet)) $display("FAIL rmid_frame: got stable=%b quiet=%b want 1 1", stable, quiet); else n_pass++;
        n_checks++; if (done_w[0] !== 1'b1) $display("FAIL rmid_done: got %b want 1", done_w[0]); else n_pass++;
        tick();
    endtask

    task automatic test_reset_accept();
        bit idle;
        data_v[0]  = 9'h000;
        valid_v[0] = 1'b1;
        reset      = 1'b1;
        tick();
        valid_v[0] = 1'b0;
        reset      = 1'b0;
        idle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (serial_w[0] !== 1'b1 || busy_w[0] !== 1'b0) idle = 1'b0;
            tick();
        end
        n_checks++; if (!idle) $display("FAIL racc_nothing_sent: got activity want idle line"); else n_pass++;
        n_checks++; if (ready_w[0] !== 1'b1) $display("FAIL racc_ready: got %b want 1", ready_w[0]); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        valid_v  = '0;
        for (int d = 0; d < 4; d++) data_v[d] = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_width_stop();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_reset_accept();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
